// File: rtl/brick_field.sv
// Breakout play-field: nine bricks plus paddle, one ball-vs-slot test per clock once per frame.
// Emits one-cycle bounce requests and holds win/lose flags until restart.
module brick_field #(
  parameter int unsigned BRICK_W  = 64,
  parameter int unsigned BRICK_H  = 16,
  parameter int unsigned PADDLE_H = 8,
  parameter int unsigned GAP      = 16,
  parameter int unsigned ORIGIN_X = 224,
  parameter int unsigned ORIGIN_Y = 64,
  parameter int unsigned PADDLE_Y = 440,
  parameter int unsigned LOSE_Y   = 479,
  parameter int unsigned SCREEN_W = 640
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        restart,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  Ball_size,
  input  logic [9:0]  paddle_x,
  output logic [8:0]  brick_exists,
  output logic [9:0]  brick_width,
  output logic [9:0]  brick_height,
  output logic [9:0]  paddle_height,
  output logic [99:0] brick_x_vals,
  output logic [99:0] brick_y_vals,
  output logic        did_win_game,
  output logic        did_lose_game,
  output logic        bounce_x,
  output logic        bounce_y,
  output logic [3:0]  hit_index
);

  localparam int unsigned PaddleMax = SCREEN_W - BRICK_W;
  localparam int unsigned PaddleRst = 288;

  typedef enum logic [1:0] {StPlay, StScan, StWin, StLose} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sync_q;  // [0],[1] synchroniser, [2] previous level for edge detect
  logic        frame_tick_q;
  logic [9:0]  paddle_x_q, ball_x_q, ball_y_q, ball_size_q;
  logic [3:0]  idx_q, idx_d;
  logic        hit_done_q, hit_done_d;
  logic [8:0]  brick_exists_q, brick_exists_d;
  logic        bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
  logic [3:0]  hit_index_q, hit_index_d;
  logic        did_win_q, did_lose_q;
  logic        latch_en;

  logic [10:0] ball_l, ball_r, ball_t, ball_b;
  logic [10:0] sx, sy, sw, sh;
  logic        alive, overlap, hit, centre_in;

  function automatic logic [10:0] slot_x(input logic [3:0] i, input logic [9:0] px);
    if (i == 4'd9) return {1'b0, px};
    return 11'(ORIGIN_X + (32'(i) % 3) * (BRICK_W + GAP));
  endfunction

  function automatic logic [10:0] slot_y(input logic [3:0] i);
    if (i == 4'd9) return 11'(PADDLE_Y);
    return 11'(ORIGIN_Y + (32'(i) / 3) * (BRICK_H + GAP));
  endfunction

  // Ball box in 11 bits; left/top saturate at zero rather than wrapping.
  always_comb begin
    ball_l = (ball_x_q < ball_size_q) ? 11'd0 : {1'b0, ball_x_q} - {1'b0, ball_size_q};
    ball_t = (ball_y_q < ball_size_q) ? 11'd0 : {1'b0, ball_y_q} - {1'b0, ball_size_q};
    ball_r = {1'b0, ball_x_q} + {1'b0, ball_size_q};
    ball_b = {1'b0, ball_y_q} + {1'b0, ball_size_q};
    sx = slot_x(idx_q, paddle_x_q);
    sy = slot_y(idx_q);
    sw = 11'(BRICK_W);
    sh = (idx_q == 4'd9) ? 11'(PADDLE_H) : 11'(BRICK_H);
    alive = (idx_q < 4'd9) ? brick_exists_q[idx_q] : 1'b1;
    overlap = (ball_l <= sx + sw - 11'd1) && (ball_r >= sx) &&
              (ball_t <= sy + sh - 11'd1) && (ball_b >= sy);
    hit = overlap && alive && !hit_done_q;
    centre_in = ({1'b0, ball_x_q} >= sx) && ({1'b0, ball_x_q} <= sx + sw - 11'd1);
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    hit_done_d     = hit_done_q;
    brick_exists_d = brick_exists_q;
    bounce_x_d     = 1'b0;
    bounce_y_d     = 1'b0;
    hit_index_d    = hit_index_q;
    latch_en       = 1'b0;
    unique case (state_q)
      StPlay: begin
        if (frame_tick_q) begin
          latch_en   = 1'b1;
          idx_d      = 4'd0;
          hit_done_d = 1'b0;
          state_d    = StScan;
        end
      end
      StScan: begin
        if (hit) begin
          hit_done_d  = 1'b1;
          bounce_y_d  = centre_in;
          bounce_x_d  = !centre_in;
          hit_index_d = idx_q;
          if (idx_q < 4'd9) brick_exists_d[idx_q] = 1'b0;
        end
        // Slot 9 never clears a brick, so the registered mask is final here.
        if (idx_q == 4'd9) begin
          if (brick_exists_q == 9'd0)        state_d = StWin;
          else if (ball_b >= 11'(LOSE_Y))    state_d = StLose;
          else                               state_d = StPlay;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StWin, StLose: begin
        if (restart) begin
          brick_exists_d = 9'h1FF;
          state_d        = StPlay;
        end
      end
      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= StPlay;
      sync_q         <= '0;
      frame_tick_q   <= 1'b0;
      paddle_x_q     <= 10'(PaddleRst);
      ball_x_q       <= '0;
      ball_y_q       <= '0;
      ball_size_q    <= '0;
      idx_q          <= '0;
      hit_done_q     <= 1'b0;
      brick_exists_q <= 9'h1FF;
      bounce_x_q     <= 1'b0;
      bounce_y_q     <= 1'b0;
      hit_index_q    <= '0;
      did_win_q      <= 1'b0;
      did_lose_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= {sync_q[1:0], frame_clk};
      frame_tick_q   <= sync_q[1] & ~sync_q[2];
      idx_q          <= idx_d;
      hit_done_q     <= hit_done_d;
      brick_exists_q <= brick_exists_d;
      bounce_x_q     <= bounce_x_d;
      bounce_y_q     <= bounce_y_d;
      hit_index_q    <= hit_index_d;
      did_win_q      <= (state_d == StWin);
      did_lose_q     <= (state_d == StLose);
      if (latch_en) begin
        paddle_x_q  <= (paddle_x > 10'(PaddleMax)) ? 10'(PaddleMax) : paddle_x;
        ball_x_q    <= BallX;
        ball_y_q    <= BallY;
        ball_size_q <= Ball_size;
      end
    end
  end

  for (genvar g = 0; g < 9; g++) begin : g_slot
    assign brick_x_vals[10*g +: 10] = 10'(ORIGIN_X + (g % 3) * (BRICK_W + GAP));
    assign brick_y_vals[10*g +: 10] = 10'(ORIGIN_Y + (g / 3) * (BRICK_H + GAP));
  end
  assign brick_x_vals[99:90] = paddle_x_q;
  assign brick_y_vals[99:90] = 10'(PADDLE_Y);

  assign brick_exists  = brick_exists_q;
  assign brick_width   = 10'(BRICK_W);
  assign brick_height  = 10'(BRICK_H);
  assign paddle_height = 10'(PADDLE_H);
  assign did_win_game  = did_win_q;
  assign did_lose_game = did_lose_q;
  assign bounce_x      = bounce_x_q;
  assign bounce_y      = bounce_y_q;
  assign hit_index     = hit_index_q;

endmodule

// File: doc/brick_field.md
Name: brick_field

Overview:
- Owns the breakout play-field state: nine bricks, the paddle, and the win/lose flags. It is the producer of the brick/paddle bus that the color mapper reads.
- Once per video frame it scans the ball against every brick and the paddle. On a hit it clears at most one brick, pulses bounce requests to the ball block, and then evaluates win/lose.
- Sits between the ball controller, the keyboard/paddle logic and the color mapper.

Parameters:
- BRICK_W, 64: brick and paddle width in pixels.
- BRICK_H, 16: brick height in pixels.
- PADDLE_H, 8: paddle height in pixels.
- GAP, 16: spacing between bricks, applied in both X and Y.
- ORIGIN_X, 224: X of brick column 0.
- ORIGIN_Y, 64: Y of brick row 0.
- PADDLE_Y, 440: fixed paddle top Y.
- LOSE_Y, 479: ball lower edge at or beyond this row means loss.
- SCREEN_W, 640: horizontal resolution, used for paddle clamping.

Ports:
- Clk, input, 1: system clock (50 MHz).
- Reset, input, 1: synchronous, active-high.
- frame_clk, input, 1: vertical sync. Asynchronous to Clk; synchronised internally.
- restart, input, 1: level; restarts the game from WIN or LOSE.
- BallX, BallY, input, 10 each: ball centre.
- Ball_size, input, 10: ball radius.
- paddle_x, input, 10: requested paddle left X.
- brick_exists, output, 9: bit i set means brick i is alive.
- brick_width, brick_height, paddle_height, output, 10 each: constants BRICK_W, BRICK_H, PADDLE_H.
- brick_x_vals, brick_y_vals, output, 100 each: slot i at [10i+9:10i]. Slots 0-8 are bricks; slot 9 is the paddle.
- did_win_game, did_lose_game, output, 1 each: game-over flags.
- bounce_x, bounce_y, output, 1 each: one-Clk pulses that tell the ball block to negate its X or Y velocity.
- hit_index, output, 4: slot that caused the last bounce (0-9). Valid while bounce_x or bounce_y is high.

Behaviour:
- Geometry:
  - Brick i: x = ORIGIN_X + (i%3)*(BRICK_W+GAP); y = ORIGIN_Y + (i/3)*(BRICK_H+GAP).
  - With defaults, column X values are 224/304/384 and row Y values are 64/96/128.
  - Brick slots are constant.
- Frame edge detection:
  - frame_clk passes through a 2-flop synchroniser and a rising-edge detector.
  - frame_tick is high for one Clk, three cycles after frame_clk rises.
- FSM states: PLAY, SCAN, WIN, LOSE. Reset enters PLAY.
  - PLAY, on frame_tick:
    - Latch paddle_x into slot 9, clamped to SCREEN_W-BRICK_W (576).
    - Latch BallX, BallY and Ball_size into scan registers.
    - Clear the scan index and go to SCAN.
  - SCAN tests one slot per Clk, in order idx = 0..9.
    - Ball box: L = BallX-size, R = BallX+size, T = BallY-size, B = BallY+size.
    - Use 11-bit arithmetic; negative L or T clamps to 0.
    - A hit requires overlap on both axes: L <= x+w-1, R >= x, T <= y+h-1, B >= y.
    - Slots 0-8 are tested only if the brick is alive; slot 9 is always tested.
  - First hit in a scan:
    - Asserts bounce_y if x <= BallX <= x+w-1; otherwise asserts bounce_x.
    - Drives hit_index = idx in the same cycle.
    - If idx < 9, clears brick_exists[idx] on that clock edge.
    - Later hits in the same scan are ignored: at most one bounce per frame.
  - After idx 9 (scan takes 10 Clk cycles):
    - If brick_exists == 0, go to WIN.
    - Else if B >= LOSE_Y, go to LOSE.
    - Else return to PLAY.
    - WIN takes priority over LOSE.
  - WIN and LOSE:
    - did_win_game or did_lose_game is held high.
    - frame_tick is ignored and the paddle is frozen.
    - restart=1 reloads brick_exists=9'h1FF, clears both flags and enters PLAY next cycle.
  - restart is ignored in PLAY and SCAN.
  - A frame_tick arriving during SCAN is dropped (a scan is far shorter than a frame).
- Reset values, and Reset asserted mid-scan (which aborts the scan):
  - brick_exists = 9'h1FF.
  - Slot 9 = (288, PADDLE_Y).
  - Flags, bounce_x, bounce_y = 0; hit_index = 0.
  - State = PLAY.
- All outputs are registered. Bounce pulses last exactly one Clk.

Test Plan:
- Reset: after release, brick_exists=1FF, brick_x_vals[9:0]=224, brick_y_vals[89:80]=128, slot 9 = (288,440), all flags 0.
- Top hit: Ball (256,78) size 4, one frame edge -> bounce_y pulse, hit_index=0, brick_exists=1FE; next frame with the same ball position -> no pulse.
- Side hit with overlap ordering: Ball (221,72) size 4 -> bounce_x, index 0. Ball box touching bricks 0 and 3 -> only brick 0 cleared that frame.
- Paddle hit and clamp: paddle_x=600, Ball (300,436) size 4 -> slot 9 x=576, no hit. Then paddle_x=270 -> bounce_y, hit_index=9, brick_exists unchanged.
- Win/lose: clear the last brick with ball B >= 479 in the same scan -> did_win_game=1, did_lose_game=0. Separately, Ball (100,476) size 4 -> did_lose_game=1; restart -> brick_exists=1FF, flags 0, PLAY.
- Reset mid-SCAN (cycle 5) and frame edge during SCAN -> abort to reset values; extra edge produces no second scan.
